bus_arbiter_router: RTL

- Two-master, three-slave bus controller that sits between the master ports and the slave memory blocks.
- Arbitrates between the masters round-robin, decodes addr[15:14] to a slave select, and sequences each transfer through the slave protocol: SETUP (sel=1, enable=0), then ACCESS (sel=1, enable=1).
- Captures read data one cycle after ACCESS and returns it to the granted master with an ack.
- Flags accesses to the unmapped region with an error.

---
 rtl/bus_arbiter_router.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_router.sv
// rtl/bus_arbiter_router.sv - two-master round-robin arbiter and three-slave setup/access sequencer
module bus_arbiter_router #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_wr,
  output logic              s_enable,
  output logic              s0_sel,
  output logic              s1_sel,
  output logic              s2_sel,
  input  logic [DATA_W-1:0] s0_rdata,
  input  logic [DATA_W-1:0] s1_rdata,
  input  logic [DATA_W-1:0] s2_rdata,
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t              r_state;
  logic                r_last_grant;
  logic                r_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr;
  logic [DATA_W-1:0]   r_wdata;
  logic [2:0]          r_sel;
  logic                r_enable;
  logic [1:0]          r_ack;
  logic                r_err;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;

  logic                w_pick;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_wr;
  logic [DATA_W-1:0]   w_wdata;
  logic [2:0]          w_sel_dec;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_rd_resp;

  // On contention the master that did not win last time gets the bus.
  assign w_pick  = (m0_req && m1_req) ? ~r_last_grant : m1_req;
  assign w_addr  = w_pick ? m1_addr  : m0_addr;
  assign w_wr    = w_pick ? m1_wr    : m0_wr;
  assign w_wdata = w_pick ? m1_wdata : m0_wdata;

  always_comb begin
    w_sel_dec = 3'b000;
    case (w_addr[ADDR_W-1:ADDR_W-2])
      2'b00:   w_sel_dec = 3'b001;
      2'b01:   w_sel_dec = 3'b010;
      2'b10:   w_sel_dec = 3'b100;
      default: w_sel_dec = 3'b000;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (r_addr[ADDR_W-1:ADDR_W-2])
      2'b00:   w_rdata = s0_rdata;
      2'b01:   w_rdata = s1_rdata;
      2'b10:   w_rdata = s2_rdata;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_addr       <= '0;
      r_wr         <= 1'b0;
      r_wdata      <= '0;
      r_sel        <= 3'b000;
      r_enable     <= 1'b0;
      r_ack        <= 2'b00;
      r_err        <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_addr       <= w_addr;
            r_wr         <= w_wr;
            r_wdata      <= w_wdata;
            r_sel        <= w_sel_dec;
            r_state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_enable <= 1'b1;
          r_state  <= S_ACCESS;
        end
        S_ACCESS: begin
          r_sel    <= 3'b000;
          r_enable <= 1'b0;
          r_ack    <= r_grant ? 2'b10 : 2'b01;
          r_err    <= &r_addr[ADDR_W-1:ADDR_W-2];
          r_state  <= S_RESP;
        end
        S_RESP: begin
          r_ack <= 2'b00;
          r_err <= 1'b0;
          if (!r_wr) begin
            if (r_grant) r_m1_rdata <= w_rdata;
            else         r_m0_rdata <= w_rdata;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read data is forwarded straight from the slave during RESP so it is valid with ack.
  assign w_rd_resp = (r_state == S_RESP) && !r_wr;
  assign m0_rdata  = (w_rd_resp && !r_grant) ? w_rdata : r_m0_rdata;
  assign m1_rdata  = (w_rd_resp &&  r_grant) ? w_rdata : r_m1_rdata;
  assign m0_ack    = r_ack[0];
  assign m1_ack    = r_ack[1];
  assign m0_err    = r_ack[0] & r_err;
  assign m1_err    = r_ack[1] & r_err;

  assign s_addr    = {2'b00, r_addr[ADDR_W-3:0]};
  assign s_wdata   = r_wdata;
  assign s_wr      = r_wr;
  assign s_enable  = r_enable;
  assign s0_sel    = r_sel[0];
  assign s1_sel    = r_sel[1];
  assign s2_sel    = r_sel[2];
  assign busy      = (r_state != S_IDLE);
  assign grant     = r_grant;

endmodule
